ex_div: RTL and testbench

// - Iterative radix-2 restoring divider used by the EX stage, directly downstream of the ID/EX pipeline register.
// - Takes register operands for DIV/DIVU and produces {remainder, quotient} for the HI/LO write path.
// - Requests a pipeline stall while a division is in flight.
// - Multi-cycle FSM, latency DATA_W+1 clocks. Supports signed and unsigned operands and annulment (squash).

---
 rtl/ex_div.sv | 149 ++++++++++++++
 tb/tb_ex_div.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} DATA_W+1 clocks after acceptance and stalls EX meanwhile.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stall_req_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                quo_neg_q, quo_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
    logic [DATA_W:0]     trial;

    // Magnitude of a two's complement operand; the most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic en);
        return (en && x[DATA_W-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;
        // Shifted partial remainder needs one extra bit before the trial subtraction.
        trial     = {rem_q, dvd_q[DATA_W-1]};

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        dvd_d     = abs_val(opdata1_i, signed_div_i);
                        dvs_d     = abs_val(opdata2_i, signed_div_i);
                        quo_neg_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        rem_neg_d = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
            end
            S_DIVZERO: begin
                result_d = '0;
                state_d  = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_DONE) begin
                    if (trial >= {1'b0, dvs_q}) begin
                        rem_d = trial[DATA_W-1:0] - dvs_q;
                        dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = trial[DATA_W-1:0];
                        dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = S_END;
                    result_d = {cond_neg(rem_q, rem_neg_q), cond_neg(dvd_q, quo_neg_q)};
                    ready_d  = 1'b1;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    // Divide-by-zero arrives here with ready still low; raise it one edge later.
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath registers are only meaningful while in ON, so they carry no reset.
    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        dvd_q     <= dvd_d;
        dvs_q     <= dvs_d;
        quo_neg_q <= quo_neg_d;
        rem_neg_q <= rem_neg_d;
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign stall_req_o = start_i & ~annul_i & ~ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed DIV/DIVU cases, annul, reset and randomized operands.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int tests = 0;
    int fails = 0;

    ex_div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, truncating division, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assumes start_i was raised before the upcoming edge (edge 0 = acceptance).
    task automatic wait_result(input string tag, input int lat, input logic [63:0] exp, input int hold);
        int k = -1;
        logic stall_dropped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            if (ready_o) begin
                k = i;
                break;
            end
            if (!stall_req_o) stall_dropped = 1'b1;
        end
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        chk({tag, "_stall_busy"}, 64'(stall_dropped), 64'd0);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall_done"}, 64'(stall_req_o), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_release"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input int hold);
        @(negedge clk);
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        #1;
        chk({tag, "_stall_accept"}, 64'(stall_req_o), 64'd1);
        wait_result(tag, (b == 32'd0) ? 2 : 33, exp, hold);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {result_o[62:0], ready_o}, 64'd0);
        chk("reset_stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 3);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 0);
        run_div("div_5_0", 32'd5, 32'd0, 1'b1, 64'd0, 1);
        run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 64'd0, 0);
        run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 0);
        run_div("divu_min_ff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 0);
        run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 0);

        // Annul part-way through ON, then a fresh division straight after.
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        for (int i = 0; i <= 10; i++) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall_low", 64'(stall_req_o), 64'd0);
        @(posedge clk); #1;
        chk("annul_cleared", {result_o[62:0], ready_o}, 64'd0);
        @(negedge clk);
        annul_i      = 1'b0;
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF_FC18;
        opdata2_i    = 32'd7;
        wait_result("after_annul", 33, ref_div(32'hFFFF_FC18, 32'd7, 1'b1), 0);

        // Reset in the middle of ON.
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd12345;
        opdata2_i    = 32'd11;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_on", {result_o[61:0], ready_o, stall_req_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst", 32'd12345, 32'd11, 1'b0, {32'd3, 32'd1122}, 0);

        // Randomized operands against the arithmetic reference.
        for (int t = 0; t < 24; t++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case (t % 6)
                1: b = 32'($urandom_range(1, 15));
                2: b = (t % 12 == 2) ? 32'd0 : 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = {b[31], 16'd0, b[14:0]};
                default: ;
            endcase
            run_div("random", a, b, s, ref_div(a, b, s), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
